// File: rtl/sys_output_deskew_if.sv
// Column-input / row-output bundle between the systolic array, the deskew
// block and the unified buffer write path.
interface sys_output_deskew_if #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ROW_CNT_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]    col1_data_in;
    logic                     col1_valid_in;
    logic [DATA_WIDTH-1:0]    col2_data_in;
    logic                     col2_valid_in;
    logic [15:0]              col_size_in;
    logic                     col_size_valid_in;
    logic                     batch_start_in;
    logic [ROW_CNT_WIDTH-1:0] rows_expected_in;
    logic [DATA_WIDTH-1:0]    out_data_1;
    logic [DATA_WIDTH-1:0]    out_data_2;
    logic                     out_valid;
    logic                     out_ready;
    logic                     batch_busy;
    logic                     batch_done;
    logic                     overflow_err;
    logic                     align_err;

    modport slave (
        input  col1_data_in, col1_valid_in, col2_data_in, col2_valid_in,
        input  col_size_in, col_size_valid_in, batch_start_in, rows_expected_in,
        input  out_ready,
        output out_data_1, out_data_2, out_valid,
        output batch_busy, batch_done, overflow_err, align_err
    );

    modport master (
        output col1_data_in, col1_valid_in, col2_data_in, col2_valid_in,
        output col_size_in, col_size_valid_in, batch_start_in, rows_expected_in,
        output out_ready,
        input  out_data_1, out_data_2, out_valid,
        input  batch_busy, batch_done, overflow_err, align_err
    );
endinterface

// File: rtl/sys_output_deskew.sv
// Realigns the skewed systolic-array column outputs into row vectors, buffers
// them in a small FIFO and tracks batch completion and data-loss errors.
module sys_output_deskew #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned ROW_CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    sys_output_deskew_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

    logic [DATA_WIDTH-1:0]    r_d1_data;
    logic                     r_d1_valid;
    logic                     r_two_col;
    logic [DATA_WIDTH-1:0]    r_mem1 [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    r_mem2 [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;
    state_t                   r_state;
    logic [ROW_CNT_WIDTH-1:0] r_rows_remaining;
    logic [ROW_CNT_WIDTH-1:0] r_rows_pushed;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_ovf;
    logic                     r_align;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_accept;
    logic                     w_ovf_set;
    logic                     w_align_set;
    logic [DATA_WIDTH-1:0]    w_row2;
    logic [CNT_W-1:0]         w_count_nxt;

    // Column 2 lags column 1 by one cycle, so it pairs with the delayed column 1.
    assign w_push      = r_two_col ? (bus.col2_valid_in & r_d1_valid) : r_d1_valid;
    assign w_align_set = r_two_col & bus.col2_valid_in & ~r_d1_valid;
    assign w_row2      = r_two_col ? bus.col2_data_in : '0;
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop       = bus.out_valid & bus.out_ready;
    assign w_accept    = w_push & (~w_full | w_pop);
    assign w_ovf_set   = w_push & w_full & ~w_pop;
    assign w_count_nxt = r_count + CNT_W'(w_accept) - CNT_W'(w_pop);

    assign bus.out_valid    = (r_count != '0);
    assign bus.out_data_1   = r_mem1[r_rd_ptr];
    assign bus.out_data_2   = r_mem2[r_rd_ptr];
    assign bus.batch_busy   = r_busy;
    assign bus.batch_done   = r_done;
    assign bus.overflow_err = r_ovf;
    assign bus.align_err    = r_align;

    // Deskew stage, column mode and row FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d1_data  <= '0;
            r_d1_valid <= 1'b0;
            r_two_col  <= 1'b1;
            r_mem1     <= '{default: '0};
            r_mem2     <= '{default: '0};
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_d1_data  <= bus.col1_data_in;
            r_d1_valid <= bus.col1_valid_in;
            if (bus.col_size_valid_in) begin
                if (bus.col_size_in == 16'd1) begin
                    r_two_col <= 1'b0;
                end else if (bus.col_size_in != 16'd0) begin
                    r_two_col <= 1'b1;
                end
            end
            if (w_accept) begin
                r_mem1[r_wr_ptr] <= r_d1_data;
                r_mem2[r_wr_ptr] <= w_row2;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Batch sequencing; completion waits for the last row to leave the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_rows_remaining <= '0;
            r_rows_pushed    <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_ovf            <= 1'b0;
            r_align          <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.batch_start_in) begin
                        r_rows_remaining <= bus.rows_expected_in;
                        r_rows_pushed    <= '0;
                        r_ovf            <= 1'b0;
                        r_align          <= 1'b0;
                        if (bus.rows_expected_in == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_push) begin
                        r_rows_remaining <= r_rows_remaining - ROW_CNT_WIDTH'(1);
                        r_rows_pushed    <= r_rows_pushed + ROW_CNT_WIDTH'(1);
                        if (r_rows_remaining == ROW_CNT_WIDTH'(1)) begin
                            if (w_count_nxt == '0) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_count_nxt == '0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            // A fresh error in the same cycle as a start still gets recorded.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
            if (w_align_set) begin
                r_align <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sys_output_deskew.sv
// Scoreboard bench for sys_output_deskew: expected rows are queued when driven
// and compared as the consumer pops them.
module tb_sys_output_deskew;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   n_pop;
    int   base;
    logic [31:0] exp_q[$];

    sys_output_deskew_if #(.DATA_WIDTH(16), .ROW_CNT_WIDTH(16)) bus ();

    sys_output_deskew #(
        .DATA_WIDTH(16), .FIFO_DEPTH(4), .ROW_CNT_WIDTH(16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two-cycle row: col1 in cycle A, matching col2 in cycle B.
    task automatic send_row(input logic [15:0] c1, input logic [15:0] c2, input logic rdy_b);
        tick();
        bus.col1_valid_in = 1'b1;
        bus.col1_data_in  = c1;
        bus.col2_valid_in = 1'b0;
        tick();
        bus.col1_valid_in = 1'b0;
        bus.col2_valid_in = 1'b1;
        bus.col2_data_in  = c2;
        bus.out_ready     = rdy_b;
        tick();
        bus.col2_valid_in = 1'b0;
        bus.out_ready     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (bus.batch_done) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic start_batch(input logic [15:0] rows);
        tick();
        bus.batch_start_in   = 1'b1;
        bus.rows_expected_in = rows;
        tick();
        bus.batch_start_in   = 1'b0;
    endtask

    // Consumer side: every accepted head must match the oldest queued row.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_row", {bus.out_data_1, bus.out_data_2}, 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("row_c1", 32'(bus.out_data_1), 32'(e[31:16]));
                chk("row_c2", 32'(bus.out_data_2), 32'(e[15:0]));
                n_pop++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0; n_err = 0; n_pop = 0; base = 0;
        rst = 1'b0;
        bus.col1_data_in = '0; bus.col1_valid_in = 1'b0;
        bus.col2_data_in = '0; bus.col2_valid_in = 1'b0;
        bus.col_size_in = '0;  bus.col_size_valid_in = 1'b0;
        bus.batch_start_in = 1'b0; bus.rows_expected_in = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", {bus.out_data_1, bus.out_data_2}, 32'd0);
        chk("rst_busy", 32'(bus.batch_busy), 32'd0);
        chk("rst_done", 32'(bus.batch_done), 32'd0);
        chk("rst_errs", {30'd0, bus.overflow_err, bus.align_err}, 32'd0);
        tick();
        rst = 1'b1;

        // Two-column alignment with exact latency
        tick();
        bus.out_ready = 1'b1;
        start_batch(16'd3);
        bus.col1_valid_in = 1'b1; bus.col1_data_in = 16'd5;           // c0
        tick();
        bus.col1_data_in = 16'd6; bus.col2_valid_in = 1'b1; bus.col2_data_in = 16'd50;
        exp_q.push_back({16'd5, 16'd50});                              // c1
        @(negedge clk); chk("t1_lat0", 32'(bus.out_valid), 32'd0);
        tick();
        bus.col1_data_in = 16'd7; bus.col2_data_in = 16'd60;
        exp_q.push_back({16'd6, 16'd60});                              // c2
        @(negedge clk); chk("t1_lat1", 32'(bus.out_valid), 32'd1);
        tick();
        bus.col1_valid_in = 1'b0; bus.col2_data_in = 16'd70;
        exp_q.push_back({16'd7, 16'd70});                              // c3
        tick();
        bus.col2_valid_in = 1'b0;                                      // c4
        @(negedge clk);
        chk("t1_done_c4", 32'(bus.batch_done), 32'd0);
        chk("t1_busy_c4", 32'(bus.batch_busy), 32'd1);
        tick();                                                        // c5
        @(negedge clk);
        chk("t1_done_c5", 32'(bus.batch_done), 32'd1);
        chk("t1_busy_c5", 32'(bus.batch_busy), 32'd0);
        chk("t1_errs", {30'd0, bus.overflow_err, bus.align_err}, 32'd0);
        chk("t1_q", 32'(exp_q.size()), 32'd0);

        // Single-column mode; col2 strobes must be ignored
        tick();
        bus.col_size_in = 16'd1; bus.col_size_valid_in = 1'b1;
        tick();
        bus.col_size_valid_in = 1'b0;
        start_batch(16'd2);
        bus.col1_valid_in = 1'b1; bus.col1_data_in = 16'd9;
        bus.col2_valid_in = 1'b1; bus.col2_data_in = 16'h00AA;
        exp_q.push_back({16'd9, 16'd0});
        tick();
        bus.col1_data_in = 16'd10; bus.col2_data_in = 16'h00BB;
        exp_q.push_back({16'd10, 16'd0});
        tick();
        bus.col1_valid_in = 1'b0; bus.col2_data_in = 16'h00CC;
        tick();
        bus.col2_valid_in = 1'b0;
        wait_done("t2_done", 20);
        chk("t2_align", 32'(bus.align_err), 32'd0);
        chk("t2_q", 32'(exp_q.size()), 32'd0);
        tick();
        bus.out_ready = 1'b0;
        bus.col_size_in = 16'd2; bus.col_size_valid_in = 1'b1;
        tick();
        bus.col_size_valid_in = 1'b0;

        // Backpressure: five rows into a four-deep FIFO
        start_batch(16'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < 4) exp_q.push_back({16'(16'h100 + k), 16'(16'h200 + k)});
            send_row(16'(16'h100 + k), 16'(16'h200 + k), 1'b0);
        end
        @(negedge clk);
        chk("t3_ovf", 32'(bus.overflow_err), 32'd1);
        chk("t3_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_busy", 32'(bus.batch_busy), 32'd1);
        chk("t3_head", {bus.out_data_1, bus.out_data_2}, {16'h100, 16'h200});
        tick();
        base = n_pop;
        bus.out_ready = 1'b1;
        wait_done("t3_done", 30);
        chk("t3_pops", 32'(n_pop - base), 32'd4);
        chk("t3_q", 32'(exp_q.size()), 32'd0);
        tick();
        bus.out_ready = 1'b0;

        // Full FIFO with a same-cycle pop and push keeps occupancy at four
        start_batch(16'd6);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({16'(16'h300 + k), 16'(16'h400 + k)});
            send_row(16'(16'h300 + k), 16'(16'h400 + k), 1'b0);
        end
        exp_q.push_back({16'h304, 16'h404});
        send_row(16'h304, 16'h404, 1'b1);
        @(negedge clk);
        chk("t4_no_ovf", 32'(bus.overflow_err), 32'd0);
        chk("t4_valid", 32'(bus.out_valid), 32'd1);
        send_row(16'h305, 16'h405, 1'b0);
        @(negedge clk);
        chk("t4_ovf_full", 32'(bus.overflow_err), 32'd1);
        tick();
        bus.out_ready = 1'b1;
        wait_done("t4_done", 30);
        chk("t4_q", 32'(exp_q.size()), 32'd0);
        tick();
        bus.out_ready = 1'b0;

        // Misalignment, then a zero-row start clears it
        tick();
        bus.col2_valid_in = 1'b1; bus.col2_data_in = 16'h0077;
        tick();
        bus.col2_valid_in = 1'b0;
        @(negedge clk);
        chk("t5_align", 32'(bus.align_err), 32'd1);
        chk("t5_nopush", 32'(bus.out_valid), 32'd0);
        tick();
        bus.batch_start_in = 1'b1; bus.rows_expected_in = 16'd0;
        tick();
        bus.batch_start_in = 1'b0;
        @(negedge clk);
        chk("t5_done0", 32'(bus.batch_done), 32'd1);
        chk("t5_busy0", 32'(bus.batch_busy), 32'd0);
        chk("t5_clear", 32'(bus.align_err), 32'd0);

        // Reset mid-batch with two rows buffered
        start_batch(16'd3);
        send_row(16'h501, 16'h601, 1'b0);
        send_row(16'h502, 16'h602, 1'b0);
        @(negedge clk);
        chk("t6_buffered", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_busy", 32'(bus.batch_busy), 32'd0);
        chk("t6_data", {bus.out_data_1, bus.out_data_2}, 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
        start_batch(16'd1);
        exp_q.push_back({16'h0055, 16'h0066});
        send_row(16'h0055, 16'h0066, 1'b0);
        bus.out_ready = 1'b1;
        wait_done("t6_done", 20);
        chk("t6_q", 32'(exp_q.size()), 32'd0);
        chk("t6_errs", {30'd0, bus.overflow_err, bus.align_err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
